hex_word_rotator: RTL and testbench

- Parametrised successor to the switch-selected 4-digit "dE0 " word display.
- Holds an NUM_DIGITS-character word of 2-bit glyph codes and drives one 7-segment display per character.
- Rotates the word autonomously on an internal divided tick, or one position per manual step pulse, in either direction.
- Top-level lab datapath block: board switches/keys in, HEX displays out.

---
 rtl/hex_word_rotator.sv | 107 ++++++++++
 tb/tb_hex_word_rotator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hex_word_rotator.sv
// Rotating word of 2-bit glyph codes shown on NUM_DIGITS active-low 7-segment displays.
// Rotates on a divided auto tick or on step rising edges; load overrides both.
module hex_word_rotator #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned TICK_DIV   = 50000000,
   parameter int unsigned POS_W      = 2
) (
   input  logic                      Clock,
   input  logic                      Resetn,
   input  logic                      load,
   input  logic [2*NUM_DIGITS-1:0]   word_in,
   input  logic                      run,
   input  logic                      dir,
   input  logic                      step,
   output logic [8*NUM_DIGITS-1:0]   HEX,
   output logic [POS_W-1:0]          pos,
   output logic                      tick
);

   localparam int unsigned WORD_W = 2 * NUM_DIGITS;
   localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // Display k powers up with code (NUM_DIGITS-1-k) mod 4, i.e. "dE0 " for four digits.
   function automatic logic [WORD_W-1:0] reset_word();
      logic [WORD_W-1:0] w;
      w = '0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         w[2*k +: 2] = 2'((NUM_DIGITS - 1 - k) % 4);
      end
      return w;
   endfunction

   localparam logic [WORD_W-1:0] RESET_WORD = reset_word();
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(NUM_DIGITS - 1);

   logic [WORD_W-1:0] word_q, word_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick_q;
   logic              step_q;
   logic              auto_ev;
   logic              step_ev;
   logic              rot_ev;

   assign auto_ev = run && (cnt_q == CNT_LAST);
   assign step_ev = step && !step_q;
   // A coincident auto and step event still rotates only once.
   assign rot_ev  = auto_ev || step_ev;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!run || load || auto_ev) begin
         cnt_d = '0;
      end
   end

   always_comb begin
      word_d = word_q;
      pos_d  = pos_q;
      if (load) begin
         word_d = word_in;
         pos_d  = '0;
      end else if (rot_ev) begin
         if (!dir) begin
            word_d = {word_q[WORD_W-3:0], word_q[WORD_W-1 -: 2]};
            pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
         end else begin
            word_d = {word_q[1:0], word_q[WORD_W-1:2]};
            pos_d  = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         word_q <= RESET_WORD;
         pos_q  <= '0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         step_q <= 1'b0;
      end else begin
         word_q <= word_d;
         pos_q  <= pos_d;
         cnt_q  <= cnt_d;
         tick_q <= auto_ev;
         step_q <= step;
      end
   end

   // Segment order a..g,dp at bits 0..7, active low; dp always off.
   always_comb begin
      HEX = '1;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         case (word_q[2*k +: 2])
            2'b00:   HEX[8*k +: 8] = 8'hA1;
            2'b01:   HEX[8*k +: 8] = 8'h86;
            2'b10:   HEX[8*k +: 8] = 8'hC0;
            default: HEX[8*k +: 8] = 8'hFF;
         endcase
      end
   end

   assign pos  = pos_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_hex_word_rotator.sv
// Bench for hex_word_rotator: directed test-plan steps then random traffic,
// checked every cycle against a glyph-array model of the rotating word.
module tb_hex_word_rotator;

   localparam int unsigned ND   = 4;
   localparam int unsigned TDIV = 4;
   localparam int unsigned PW   = 2;

   logic              Clock;
   logic              Resetn;
   logic              load;
   logic [2*ND-1:0]   word_in;
   logic              run;
   logic              dir;
   logic              step;
   logic [8*ND-1:0]   HEX;
   logic [PW-1:0]     pos;
   logic              tick;

   hex_word_rotator #(
      .NUM_DIGITS (ND),
      .TICK_DIV   (TDIV),
      .POS_W      (PW)
   ) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .load    (load),
      .word_in (word_in),
      .run     (run),
      .dir     (dir),
      .step    (step),
      .HEX     (HEX),
      .pos     (pos),
      .tick    (tick)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   // Model: glyph code per display, rotation offset, consecutive run-high cycles.
   int glyph [ND];
   int m_pos;
   int run_cnt;
   bit prev_step;
   bit m_tick;

   function automatic logic [7:0] seg(input int g);
      case (g)
         0:       return 8'hA1;
         1:       return 8'h86;
         2:       return 8'hC0;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < int'(ND); k++) glyph[k] = (int'(ND) - 1 - k) % 4;
      m_pos     = 0;
      run_cnt   = 0;
      prev_step = 1'b0;
      m_tick    = 1'b0;
   endtask

   task automatic check(input string tag);
      logic [8*ND-1:0] exp_hex;
      for (int k = 0; k < int'(ND); k++) exp_hex[8*k +: 8] = seg(glyph[k]);
      checks += 3;
      assert (HEX === exp_hex) else begin
         errors++;
         $error("FAIL %s hex: got %h expected %h", tag, HEX, exp_hex);
      end
      assert (pos === PW'(m_pos)) else begin
         errors++;
         $error("FAIL %s pos: got %0d expected %0d", tag, pos, m_pos);
      end
      assert (tick === m_tick) else begin
         errors++;
         $error("FAIL %s tick: got %b expected %b", tag, tick, m_tick);
      end
   endtask

   task automatic cycle(input logic ld, input logic [2*ND-1:0] wi, input logic rn,
                        input logic dr, input logic st, input string tag);
      int  old [ND];
      bit  auto_ev;
      bit  step_ev;
      load    = ld;
      word_in = wi;
      run     = rn;
      dir     = dr;
      step    = st;
      auto_ev   = rn && (run_cnt % int'(TDIV) == int'(TDIV) - 1);
      step_ev   = st && !prev_step;
      prev_step = st;
      if (ld) begin
         for (int k = 0; k < int'(ND); k++) glyph[k] = int'(wi[2*k +: 2]);
         m_pos = 0;
      end else if (auto_ev || step_ev) begin
         old = glyph;
         for (int k = 0; k < int'(ND); k++) begin
            if (!dr) glyph[k] = old[(k + int'(ND) - 1) % int'(ND)];
            else     glyph[k] = old[(k + 1) % int'(ND)];
         end
         m_pos = dr ? (m_pos + int'(ND) - 1) % int'(ND) : (m_pos + 1) % int'(ND);
      end
      run_cnt = (ld || !rn) ? 0 : run_cnt + 1;
      m_tick  = auto_ev;
      @(posedge Clock);
      #1;
      check(tag);
   endtask

   task automatic do_reset();
      load   = 1'b0;
      run    = 1'b0;
      step   = 1'b0;
      Resetn = 1'b0;
      #1;
      model_reset();
      check("reset_async");
      @(posedge Clock);
      #1;
      check("reset_held");
      Resetn = 1'b1;
   endtask

   initial begin
      Resetn  = 1'b0;
      load    = 1'b0;
      word_in = '0;
      run     = 1'b0;
      dir     = 1'b0;
      step    = 1'b0;
      model_reset();
      @(posedge Clock);
      #1;
      do_reset();
      checks++;
      assert (HEX === 32'hA186C0FF) else begin
         errors++;
         $error("FAIL reset_const hex: got %h expected %h", HEX, 32'hA186C0FF);
      end

      // Auto rotation left: ticks on cycles 4, 8, 12, 16.
      repeat (16) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "auto_left");
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, "run_off");

      // Held step rotates once per rising edge, rightwards.
      repeat (10) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, "step_held");
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, "step_low");
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, "step_again");
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, "step_release");

      // Load coincident with an auto event.
      repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "pre_load");
      cycle(1'b1, 8'b01_01_00_10, 1'b1, 1'b0, 1'b0, "load_vs_auto");
      repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "post_load");

      // Step edge coincident with an auto event.
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, "clear_cnt");
      repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "pre_coinc");
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, "step_and_auto");
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "post_coinc");

      // Reset mid-run after two rotations.
      cycle(1'b1, 8'b00_01_10_11, 1'b0, 1'b0, 1'b0, "reload");
      repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "pre_reset_run");
      do_reset();
      repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, "post_reset_run");

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            cycle(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 7) != 0),
                  1'($urandom), 1'($urandom), "random");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
